// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 9N1 UART transmitter
// One start bit, nine data bits LSB first, one stop bit; every bit lasts CLKS_PER_BIT clocks.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       send,
  input  logic [8:0] data,
  output logic       tx,
  output logic       ready
);

  localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LAST_BIT    = 4'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic [8:0]  shift_reg;

  wire bit_done = (baud_cnt == 16'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      baud_cnt  <= 16'd0;
      bit_cnt   <= 4'd0;
      shift_reg <= 9'd0;
      tx        <= 1'b1;
      ready     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx    <= 1'b1;
          ready <= 1'b1;
          if (send && ready) begin
            state     <= START;
            shift_reg <= data;
            baud_cnt  <= BAUD_RELOAD;
            bit_cnt   <= 4'd0;
            tx        <= 1'b0;
            ready     <= 1'b0;
          end
        end

        START: begin
          if (bit_done) begin
            // Shifting as each bit goes out keeps the next bit at shift_reg[0].
            state     <= DATA;
            tx        <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[8:1]};
            bit_cnt   <= 4'd0;
            baud_cnt  <= BAUD_RELOAD;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end

        DATA: begin
          if (bit_done) begin
            baud_cnt <= BAUD_RELOAD;
            if (bit_cnt == LAST_BIT) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              tx        <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[8:1]};
              bit_cnt   <= bit_cnt + 4'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end

        STOP: begin
          if (bit_done) begin
            state <= IDLE;
            ready <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end

        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx
// Instance a runs at the default bit time, instance b at 4 clocks per bit.
module tb_uart_tx;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       send_a, send_b;
  logic [8:0] data_a, data_b;
  logic       tx_a, tx_b, ready_a, ready_b;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  uart_tx #(.CLKS_PER_BIT(434)) dut_a (
    .clock(clock), .reset_n(reset_n), .send(send_a), .data(data_a), .tx(tx_a), .ready(ready_a)
  );

  uart_tx #(.CLKS_PER_BIT(4)) dut_b (
    .clock(clock), .reset_n(reset_n), .send(send_b), .data(data_b), .tx(tx_b), .ready(ready_b)
  );

  task automatic drive(input bit sel, input logic s, input logic [8:0] d);
    if (sel) begin
      send_b = s;
      data_b = d;
    end else begin
      send_a = s;
      data_a = d;
    end
  endtask

  // Expected line level at cycle k after acceptance: bit (k-1)/n of {stop, data, start}.
  task automatic frame(input bit sel, input logic [8:0] d, input bit keep_send,
                       input int poke_k, input string name, output logic [63:0] wave);
    int          n = sel ? 4 : 434;
    logic [10:0] bits;
    int          bad = 0, first_k = -1, low = 0;
    logic        exp_tx, exp_rdy, got_tx, got_rdy;
    logic        f_tx, f_rdy, fe_tx, fe_rdy;
    bits = {1'b1, d, 1'b0};
    wave = 64'd0;
    f_tx = 1'b0; f_rdy = 1'b0; fe_tx = 1'b0; fe_rdy = 1'b0;
    drive(sel, 1'b1, d);
    @(posedge clock);
    for (int k = 1; k <= 11 * n + 1; k++) begin
      @(negedge clock);
      if (k == 1 && !keep_send) drive(sel, 1'b0, 9'($urandom));
      if (poke_k != 0 && k == poke_k) drive(sel, 1'b1, 9'h0FF);
      if (poke_k != 0 && k == poke_k + 1) drive(sel, 1'b0, 9'h0FF);
      exp_tx  = (k <= 11 * n) ? bits[(k - 1) / n] : 1'b1;
      exp_rdy = (k > 11 * n);
      got_tx  = sel ? tx_b : tx_a;
      got_rdy = sel ? ready_b : ready_a;
      if (got_tx !== exp_tx || got_rdy !== exp_rdy) begin
        if (first_k < 0) begin
          first_k = k; f_tx = got_tx; f_rdy = got_rdy; fe_tx = exp_tx; fe_rdy = exp_rdy;
        end
        bad++;
      end
      if (got_rdy === 1'b0) low++;
      if (k <= 11 * n) wave = {wave[62:0], got_tx};
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL %s waveform: %0d bad cycles, first at cycle %0d got tx=%b ready=%b expected tx=%b ready=%b",
               name, bad, first_k, f_tx, f_rdy, fe_tx, fe_rdy);
    end
    compared++;
    if (low !== 11 * n) begin
      mismatched++;
      $display("FAIL %s ready_low: got %0d cycles expected %0d", name, low, 11 * n);
    end
  endtask

  task automatic idle_check(input bit sel, input int cycles, input string name);
    int bad = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clock);
      if ((sel ? tx_b : tx_a) !== 1'b1 || (sel ? ready_b : ready_a) !== 1'b1) bad++;
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL %s idle: got %0d non-idle cycles expected 0", name, bad);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    drive(0, 1'b1, 9'h1AB);
    drive(1, 1'b1, 9'h0CD);
    repeat (3) @(negedge clock);
    compared += 4;
    if (tx_a !== 1'b1)    begin mismatched++; $display("FAIL reset tx_a: got %b expected 1", tx_a); end
    if (ready_a !== 1'b1) begin mismatched++; $display("FAIL reset ready_a: got %b expected 1", ready_a); end
    if (tx_b !== 1'b1)    begin mismatched++; $display("FAIL reset tx_b: got %b expected 1", tx_b); end
    if (ready_b !== 1'b1) begin mismatched++; $display("FAIL reset ready_b: got %b expected 1", ready_b); end
    drive(0, 1'b0, 9'h000);
    drive(1, 1'b0, 9'h000);
    reset_n = 1'b1;
    idle_check(0, 5, "post_reset_a");
    idle_check(1, 5, "post_reset_b");
  endtask

  task automatic test_single;
    logic [63:0] w;
    frame(0, 9'h155, 0, 0, "single_155", w);
  endtask

  task automatic test_extremes;
    logic [63:0] w;
    frame(0, 9'h000, 0, 0, "all_zero", w);
    idle_check(0, 3, "gap_zero");
    frame(0, 9'h1FF, 0, 0, "all_one", w);
    idle_check(0, 3, "gap_one");
  endtask

  task automatic test_back_to_back;
    logic [63:0] w;
    frame(0, 9'h0A5, 1, 0, "hold_1", w);
    frame(0, 9'h0A5, 1, 0, "hold_2", w);
    frame(0, 9'h0A5, 0, 0, "hold_3", w);
    idle_check(0, 868, "hold_after");
  endtask

  task automatic test_data_change;
    logic [63:0] w;
    frame(0, 9'($urandom), 0, 3 * 434, "data_change", w);
    idle_check(0, 20, "no_queue");
  endtask

  task automatic test_reset_mid;
    logic [8:0]  d = 9'($urandom);
    logic [10:0] bits;
    bits = {1'b1, d, 1'b0};
    drive(0, 1'b1, d);
    @(posedge clock);
    @(negedge clock);
    drive(0, 1'b0, d);
    repeat (1999) @(negedge clock);
    compared++;
    if (tx_a !== bits[4]) begin
      mismatched++;
      $display("FAIL reset_mid pre: got tx=%b expected %b", tx_a, bits[4]);
    end
    reset_n = 1'b0;
    #1;
    compared += 2;
    if (tx_a !== 1'b1)    begin mismatched++; $display("FAIL reset_mid tx: got %b expected 1", tx_a); end
    if (ready_a !== 1'b1) begin mismatched++; $display("FAIL reset_mid ready: got %b expected 1", ready_a); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    idle_check(0, 868, "reset_mid_after");
  endtask

  task automatic test_fast_wave;
    logic [63:0] w;
    logic [43:0] exp_w;
    exp_w = 44'h0F00000000F;
    frame(1, 9'h001, 0, 0, "fast_001", w);
    compared++;
    if (w[43:0] !== exp_w) begin
      mismatched++;
      $display("FAIL fast_wave: got %h expected %h", w[43:0], exp_w);
    end
  endtask

  task automatic test_random;
    logic [63:0] w;
    int gap, poke;
    for (int i = 0; i < 24; i++) begin
      gap  = $urandom_range(0, 3);
      poke = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 40)) : 0;
      if (gap > 0) idle_check(1, gap, "rand_gap");
      frame(1, 9'($urandom), 0, poke, "rand_fast", w);
    end
    frame(0, 9'($urandom), 0, 0, "rand_slow", w);
  endtask

  initial begin
    reset_n = 1'b0;
    send_a = 1'b0; send_b = 1'b0;
    data_a = 9'd0; data_b = 9'd0;
    @(negedge clock);
    test_reset;
    test_single;
    test_extremes;
    test_back_to_back;
    test_data_change;
    test_reset_mid;
    test_fast_wave;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, giving clock cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have port clock, input, 1 bit; the single clock, all state updates on the rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have port send, input, 1 bit; request to transmit data, sampled on the rising edge.
REQ-005 SHALL have port data, input, 9 bits; payload to transmit, sampled only when a send is accepted.
REQ-006 SHALL have port tx, output, 1 bit; serial line, idle high.
REQ-007 SHALL have port ready, output, 1 bit; high when idle and able to accept a send.

Function
REQ-008 SHALL implement 9N1 framing: 1 start bit (0), 9 data bits LSB first (data[0] first), no parity, 1 stop bit (1).
REQ-009 SHALL make a frame 11 bit-times long (11*CLKS_PER_BIT cycles), each bit held on tx for exactly CLKS_PER_BIT cycles.
REQ-010 SHALL use states IDLE, START, DATA, STOP.
REQ-011 SHALL accept a send on any rising edge where send=1 and ready=1, and then latch data into an internal 9-bit shift register.
REQ-012 SHALL go from IDLE to START on acceptance, with tx=0 and ready=0 from the cycle after the accepting edge (1-cycle latency).
REQ-013 SHALL go from START to DATA after CLKS_PER_BIT cycles.
REQ-014 SHALL stay in DATA for 9 bit-times, driving bit index 0..8 in turn, with a 4-bit bit counter checked against 8.
REQ-015 SHALL go from DATA to STOP after bit 8 completes, with tx=1.
REQ-016 SHALL go from STOP to IDLE after CLKS_PER_BIT cycles, with ready=1 on the first IDLE cycle.
REQ-017 SHALL ignore send while ready=0, with no queuing and the current frame unaffected.
REQ-018 SHALL NOT let changes on data after acceptance affect the frame in flight.
REQ-019 SHALL support back-to-back frames: if send=1 on the first IDLE cycle, the next start bit begins on the following cycle, so a minimum idle gap of 1 cycle at tx=1 follows the stop bit.
REQ-020 SHALL keep tx=1 and ready=1 in IDLE whenever send=0, with no spurious transitions.
REQ-021 SHALL implement the baud counter as a 16-bit down- or up-counter that reloads on every bit boundary, with no drift across a frame.
REQ-022 SHALL drive tx from a register, so tx is glitch-free.

Reset
REQ-023 SHALL force state=IDLE, tx=1, ready=1, and clear counters and the shift register immediately on reset_n=0, asynchronously.
REQ-024 SHALL abort any frame in progress on reset mid-frame, with tx returning to 1 at once and no resumption after release.
REQ-025 SHALL make the first accepted send after reset_n deasserts begin a fresh frame per REQ-012.
REQ-026 SHALL ignore send while reset_n=0.

Verification
REQ-027 SHALL cover single frame: reset, then data=9'h155 and send pulsed 1 cycle (CLKS_PER_BIT=434). Required response: tx=0 for 434 cycles, then bits 1,0,1,0,1,0,1,0,1 each for 434 cycles, then 1 for 434 cycles, with ready low for exactly 4774 cycles and then high.
REQ-028 SHALL cover data=9'h000 and 9'h1FF frames: tx holds 0 for 10 bit-times, or shows only the start bit low, with stop bit=1 in both cases.
REQ-029 SHALL cover send held high continuously for 3 frames of 9'h0A5: exactly 3 frames, each 4774 cycles, separated by 1-cycle idle high gaps.
REQ-030 SHALL cover send pulsed and data changed to 9'h0FF during the DATA state: the transmitted bits still match the originally latched value, and the second send is ignored.
REQ-031 SHALL cover reset_n asserted mid-DATA (e.g., cycle 2000): tx=1 and ready=1 within the same cycle, and idle thereafter until a new send.
REQ-032 SHALL cover CLKS_PER_BIT=4 with data=9'h001: the exact cycle-by-cycle tx waveform is 4 zeros, 4 ones, 32 zeros, 4 ones (44 cycles).
